// File: rtl/alu_unit.sv
// Integer ALU with a 4-deep result FIFO that feeds a common data bus.
// Optional branch statistics counters are enabled by defining ALU_BRANCH_STAT_EN.
module alu_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic        in_config,
    input  logic [31:0] in_value_1,
    input  logic [31:0] in_value_2,
    input  logic [31:0] in_value_pc,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_precise,
    input  logic        in_more_precise,
    input  logic [31:0] in_imm,
    input  logic [3:0]  in_rob_entry,
    input  logic        cdb_grant,
    output logic        out_config,
    output logic [31:0] out_val,
    output logic [3:0]  out_rob_entry,
    output logic        out_jump,
    output logic [31:0] out_target_pc,
    output logic        almost_full
`ifdef ALU_BRANCH_STAT_EN
    ,
    output logic [31:0] stat_branch_cnt,
    output logic [31:0] stat_taken_cnt
`endif
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [31:0] val;
        logic [3:0]  rob_entry;
        logic        jump;
        logic [31:0] target;
    } result_t;

    function automatic logic [31:0] alu_op(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [2:0]  funct3,
        input logic        alt_sub,
        input logic        alt_sra
    );
        logic [4:0]         sh;
        logic signed [31:0] sra_res;
        logic [31:0]        res;
        sh = b[4:0];
        // Kept in its own signed variable so the shift stays arithmetic.
        sra_res = $signed(a) >>> sh;
        case (funct3)
            3'b000:  res = alt_sub ? a - b : a + b;
            3'b001:  res = a << sh;
            3'b010:  res = {31'b0, $signed(a) < $signed(b)};
            3'b011:  res = {31'b0, a < b};
            3'b100:  res = a ^ b;
            3'b101:  res = alt_sra ? sra_res : a >> sh;
            3'b110:  res = a | b;
            default: res = a & b;
        endcase
        return res;
    endfunction

    result_t     issue_res;
    logic        taken;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus_imm;

    always_comb begin
        // NOTE: every output of this block is assigned a default first so no latch can be inferred.
        pc_plus4    = in_value_pc + 32'd4;
        pc_plus_imm = in_value_pc + in_imm;
        taken       = 1'b0;
        issue_res           = '0;
        issue_res.rob_entry = in_rob_entry;
        issue_res.target    = pc_plus4;
        case (in_opcode)
            OPC_OP:     issue_res.val = alu_op(in_value_1, in_value_2, in_precise,
                                               in_more_precise, in_more_precise);
            OPC_OP_IMM: issue_res.val = alu_op(in_value_1, in_imm, in_precise,
                                               1'b0, in_more_precise);
            OPC_LUI:    issue_res.val = in_imm;
            OPC_AUIPC:  issue_res.val = pc_plus_imm;
            OPC_JAL: begin
                issue_res.val    = pc_plus4;
                issue_res.jump   = 1'b1;
                issue_res.target = pc_plus_imm;
            end
            OPC_JALR: begin
                issue_res.val    = pc_plus4;
                issue_res.jump   = 1'b1;
                issue_res.target = (in_value_1 + in_imm) & ~32'd1;
            end
            OPC_BRANCH: begin
                case (in_precise)
                    3'b000:  taken = in_value_1 == in_value_2;
                    3'b001:  taken = in_value_1 != in_value_2;
                    3'b100:  taken = $signed(in_value_1) <  $signed(in_value_2);
                    3'b101:  taken = $signed(in_value_1) >= $signed(in_value_2);
                    3'b110:  taken = in_value_1 <  in_value_2;
                    3'b111:  taken = in_value_1 >= in_value_2;
                    default: taken = 1'b0;
                endcase
                issue_res.jump   = taken;
                issue_res.target = taken ? pc_plus_imm : pc_plus4;
            end
            default: issue_res.val = '0;
        endcase
    end

    result_t    fifo_mem [0:3];
    logic [1:0] head;
    logic [1:0] tail;
    logic [2:0] count;
    logic       do_flush;
    logic       do_pop;
    logic       do_push;

    // A pop frees a slot on the same edge, so a full FIFO still accepts a push alongside a grant.
    assign do_flush = rdy & rollback;
    assign do_pop   = rdy & ~rollback & cdb_grant & (count != 3'd0);
    assign do_push  = rdy & ~rollback & in_config & ((count != 3'd4) | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            head  <= 2'd0;
            tail  <= 2'd0;
            count <= 3'd0;
        end else if (do_flush) begin
            head  <= 2'd0;
            tail  <= 2'd0;
            count <= 3'd0;
        end else begin
            if (do_push) tail <= tail + 2'd1;
            if (do_pop)  head <= head + 2'd1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; stale entries are never visible because outputs are masked by count.
    always_ff @(posedge clk) begin
        if (do_push) fifo_mem[tail] <= issue_res;
    end

    result_t head_res;
    assign head_res      = fifo_mem[head];
    assign out_config    = count != 3'd0;
    assign almost_full   = count >= 3'd3;
    assign out_val       = out_config ? head_res.val       : 32'd0;
    assign out_rob_entry = out_config ? head_res.rob_entry : 4'd0;
    assign out_jump      = out_config ? head_res.jump      : 1'b0;
    assign out_target_pc = out_config ? head_res.target    : 32'd0;

`ifdef ALU_BRANCH_STAT_EN
    logic push_branch;
    assign push_branch = do_push & (in_opcode == OPC_BRANCH);

    // Statistics survive rollback; only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_branch_cnt <= 32'd0;
            stat_taken_cnt  <= 32'd0;
        end else if (push_branch) begin
            stat_branch_cnt <= stat_branch_cnt + 32'd1;
            if (issue_res.jump) stat_taken_cnt <= stat_taken_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed cases plus random traffic against a
// queue-based reference model of the result FIFO.
module tb_alu_unit;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic        in_config;
    logic [31:0] in_value_1;
    logic [31:0] in_value_2;
    logic [31:0] in_value_pc;
    logic [6:0]  in_opcode;
    logic [2:0]  in_precise;
    logic        in_more_precise;
    logic [31:0] in_imm;
    logic [3:0]  in_rob_entry;
    logic        cdb_grant;
    logic        out_config;
    logic [31:0] out_val;
    logic [3:0]  out_rob_entry;
    logic        out_jump;
    logic [31:0] out_target_pc;
    logic        almost_full;
`ifdef ALU_BRANCH_STAT_EN
    logic [31:0] stat_branch_cnt;
    logic [31:0] stat_taken_cnt;
    logic [31:0] exp_branch_cnt;
    logic [31:0] exp_taken_cnt;
`endif

    alu_unit dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .rollback        (rollback),
        .in_config       (in_config),
        .in_value_1      (in_value_1),
        .in_value_2      (in_value_2),
        .in_value_pc     (in_value_pc),
        .in_opcode       (in_opcode),
        .in_precise      (in_precise),
        .in_more_precise (in_more_precise),
        .in_imm          (in_imm),
        .in_rob_entry    (in_rob_entry),
        .cdb_grant       (cdb_grant),
        .out_config      (out_config),
        .out_val         (out_val),
        .out_rob_entry   (out_rob_entry),
        .out_jump        (out_jump),
        .out_target_pc   (out_target_pc),
        .almost_full     (almost_full)
`ifdef ALU_BRANCH_STAT_EN
        ,
        .stat_branch_cnt (stat_branch_cnt),
        .stat_taken_cnt  (stat_taken_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        logic [3:0]  rob;
        logic        jump;
        logic [31:0] target;
    } exp_t;

    exp_t scoreboard[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the architectural meaning of one issued instruction.
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                   input logic [31:0] v1, input logic [31:0] v2,
                                   input logic [31:0] pc, input logic [31:0] imm,
                                   input logic [3:0] rob);
        exp_t               e;
        logic [31:0]        b;
        logic signed [31:0] sv1;
        logic signed [31:0] sv2;
        logic signed [31:0] shifted;
        bit                 cond;
        e.val = 32'd0; e.rob = rob; e.jump = 1'b0; e.target = pc + 32'd4;
        if (op == OP || op == OP_IMM) begin
            b   = (op == OP) ? v2 : imm;
            sv1 = v1;
            sv2 = b;
            shifted = sv1 >>> b[4:0];
            case (f3)
                3'd0: e.val = (op == OP && f7) ? v1 - b : v1 + b;
                3'd1: e.val = v1 << b[4:0];
                3'd2: e.val = (sv1 < sv2) ? 32'd1 : 32'd0;
                3'd3: e.val = (v1 < b) ? 32'd1 : 32'd0;
                3'd4: e.val = v1 ^ b;
                3'd5: e.val = f7 ? shifted : v1 >> b[4:0];
                3'd6: e.val = v1 | b;
                default: e.val = v1 & b;
            endcase
        end else if (op == LUI) begin
            e.val = imm;
        end else if (op == AUIPC) begin
            e.val = pc + imm;
        end else if (op == JAL) begin
            e.val = pc + 32'd4; e.jump = 1'b1; e.target = pc + imm;
        end else if (op == JALR) begin
            e.val = pc + 32'd4; e.jump = 1'b1; e.target = (v1 + imm) & 32'hFFFF_FFFE;
        end else if (op == BRANCH) begin
            sv1 = v1;
            sv2 = v2;
            case (f3)
                3'd0: cond = v1 == v2;
                3'd1: cond = v1 != v2;
                3'd4: cond = sv1 < sv2;
                3'd5: cond = sv1 >= sv2;
                3'd6: cond = v1 < v2;
                3'd7: cond = v1 >= v2;
                default: cond = 1'b0;
            endcase
            e.jump = cond;
            if (cond) e.target = pc + imm;
        end
        return e;
    endfunction

    // Monitor: compares the DUT head with the scoreboard, then applies the coming edge to the model.
    always @(negedge clk) begin
        if (!rst) begin
            scoreboard.delete();
`ifdef ALU_BRANCH_STAT_EN
            exp_branch_cnt = 32'd0;
            exp_taken_cnt  = 32'd0;
`endif
            check("rst_out_config", 32'(out_config), 32'd0);
            check("rst_almost_full", 32'(almost_full), 32'd0);
            check("rst_out_val", out_val, 32'd0);
        end else begin
            bit   do_pop;
            bit   do_push;
            exp_t e;
            check("mon_out_config", 32'(out_config), 32'(scoreboard.size() != 0));
            check("mon_almost_full", 32'(almost_full), 32'(scoreboard.size() >= 3));
            if (scoreboard.size() != 0) begin
                check("mon_val", out_val, scoreboard[0].val);
                check("mon_rob", 32'(out_rob_entry), 32'(scoreboard[0].rob));
                check("mon_jump", 32'(out_jump), 32'(scoreboard[0].jump));
                check("mon_target", out_target_pc, scoreboard[0].target);
            end
`ifdef ALU_BRANCH_STAT_EN
            check("stat_branch", stat_branch_cnt, exp_branch_cnt);
            check("stat_taken", stat_taken_cnt, exp_taken_cnt);
`endif
            if (rdy) begin
                if (rollback) begin
                    scoreboard.delete();
                end else begin
                    do_pop  = cdb_grant && scoreboard.size() != 0;
                    do_push = in_config && (scoreboard.size() < 4 || do_pop);
                    if (do_pop) void'(scoreboard.pop_front());
                    if (do_push) begin
                        e = model(in_opcode, in_precise, in_more_precise, in_value_1, in_value_2,
                                  in_value_pc, in_imm, in_rob_entry);
                        scoreboard.push_back(e);
`ifdef ALU_BRANCH_STAT_EN
                        if (in_opcode == BRANCH) begin
                            exp_branch_cnt = exp_branch_cnt + 32'd1;
                            if (e.jump) exp_taken_cnt = exp_taken_cnt + 32'd1;
                        end
`endif
                    end
                end
            end
        end
    end

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [3:0] rob);
        in_config = 1'b1; in_opcode = op; in_precise = f3; in_more_precise = f7;
        in_value_1 = v1; in_value_2 = v2; in_value_pc = pc; in_imm = imm; in_rob_entry = rob;
    endtask

    // Advances one clock and returns 1 time unit after the edge with control inputs idle.
    task automatic step();
        @(posedge clk);
        #1;
        in_config = 1'b0; cdb_grant = 1'b0; rollback = 1'b0;
    endtask

    task automatic pop_one();
        cdb_grant = 1'b1;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [6:0] op_list [8];

    initial begin
        op_list = '{OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, 7'b0000000};
        rst = 1'b0; rdy = 1'b1; rollback = 1'b0; cdb_grant = 1'b0;
        in_config = 1'b0; in_value_1 = '0; in_value_2 = '0; in_value_pc = '0;
        in_opcode = '0; in_precise = '0; in_more_precise = 1'b0; in_imm = '0; in_rob_entry = '0;
        #3;
        check("reset_config", 32'(out_config), 32'd0);
        check("reset_target", out_target_pc, 32'd0);
        check("reset_rob", 32'(out_rob_entry), 32'd0);
        check("reset_jump", 32'(out_jump), 32'd0);
        step(); step();
        rst = 1'b1;
        step();

        // ADD
        drive(OP, 3'b000, 1'b0, 32'd5, 32'd7, 32'h0, 32'h0, 4'd3); step();
        check("add_config", 32'(out_config), 32'd1);
        check("add_val", out_val, 32'd12);
        check("add_rob", 32'(out_rob_entry), 32'd3);
        check("add_jump", 32'(out_jump), 32'd0);
        pop_one();
        check("add_drained", 32'(out_config), 32'd0);

        // SRAI
        drive(OP_IMM, 3'b101, 1'b1, 32'h8000_0000, 32'h0, 32'h0, 32'd4, 4'd1); step();
        check("sra_val", out_val, 32'hF800_0000);
        pop_one();

        // BLT taken / BLTU not taken on the same operands
        drive(BRANCH, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 4'd2); step();
        check("blt_jump", 32'(out_jump), 32'd1);
        check("blt_target", out_target_pc, 32'h120);
        pop_one();
        drive(BRANCH, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 4'd2); step();
        check("bltu_jump", 32'(out_jump), 32'd0);
        check("bltu_target", out_target_pc, 32'h104);
        pop_one();

        // JALR clears bit 0 of the target
        drive(JALR, 3'b000, 1'b0, 32'h1003, 32'h0, 32'h40, 32'd2, 4'd4); step();
        check("jalr_val", out_val, 32'h44);
        check("jalr_target", out_target_pc, 32'h1004);
        check("jalr_jump", 32'(out_jump), 32'd1);
        pop_one();

        // Fill, drop while full, push+pop while full, then drain in order
        for (int i = 1; i <= 4; i++) begin
            drive(OP, 3'b000, 1'b0, 32'(i), 32'd0, 32'h0, 32'h0, 4'(i)); step();
            if (i == 2) check("fill_af_at2", 32'(almost_full), 32'd0);
            if (i == 3) check("fill_af_at3", 32'(almost_full), 32'd1);
        end
        drive(OP, 3'b000, 1'b0, 32'd6, 32'd0, 32'h0, 32'h0, 4'd6); step();
        check("full_drop_head", 32'(out_rob_entry), 32'd1);
        drive(OP, 3'b000, 1'b0, 32'd5, 32'd0, 32'h0, 32'h0, 4'd5); cdb_grant = 1'b1; step();
        check("full_pushpop_af", 32'(almost_full), 32'd1);
        for (int r = 2; r <= 5; r++) begin
            check("drain_order", 32'(out_rob_entry), 32'(r));
            pop_one();
        end
        check("drain_empty", 32'(out_config), 32'd0);

        // Rollback with two queued and a concurrent issue + grant
        drive(LUI, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 32'hABCD_E000, 4'd7); step();
        drive(AUIPC, 3'b000, 1'b0, 32'h0, 32'h0, 32'h1000, 32'h10, 4'd8); step();
        drive(OP, 3'b000, 1'b0, 32'd1, 32'd1, 32'h0, 32'h0, 4'd9);
        rollback = 1'b1; cdb_grant = 1'b1; step();
        check("rollback_config", 32'(out_config), 32'd0);
        check("rollback_af", 32'(almost_full), 32'd0);
        drive(JAL, 3'b000, 1'b0, 32'h0, 32'h0, 32'h200, 32'h80, 4'd10); step();
        check("after_rb_rob", 32'(out_rob_entry), 32'd10);
        check("after_rb_target", out_target_pc, 32'h280);
        pop_one();

        // rdy=0 freezes push and pop
        rdy = 1'b0;
        drive(OP, 3'b000, 1'b0, 32'd1, 32'd2, 32'h0, 32'h0, 4'd11); step();
        check("stall_no_push", 32'(out_config), 32'd0);
        rdy = 1'b1;
        drive(OP, 3'b000, 1'b1, 32'd1, 32'd2, 32'h0, 32'h0, 4'd11); step();
        rdy = 1'b0; cdb_grant = 1'b1; step();
        check("stall_no_pop", 32'(out_config), 32'd1);
        check("sub_wrap", out_val, 32'hFFFF_FFFF);
        rdy = 1'b1; pop_one();

        // Asynchronous reset in the middle of traffic
        drive(OP, 3'b001, 1'b0, 32'd1, 32'd31, 32'h0, 32'h0, 4'd12); step();
        drive(OP, 3'b010, 1'b0, 32'd1, 32'd2, 32'h0, 32'h0, 4'd13); step();
        rst = 1'b0; #1;
        check("async_rst_config", 32'(out_config), 32'd0);
        check("async_rst_val", out_val, 32'd0);
        step();
        rst = 1'b1;
        drive(OP, 3'b001, 1'b0, 32'd1, 32'd31, 32'h0, 32'h0, 4'd14); step();
        check("post_rst_rob", 32'(out_rob_entry), 32'd14);
        check("post_rst_sll", out_val, 32'h8000_0000);
        pop_one();

        // Random traffic; the monitor checks every cycle
        repeat (3000) begin
            logic [31:0] a;
            a = $urandom;
            rdy       = ($urandom_range(0, 9) != 0);
            rollback  = ($urandom_range(0, 39) == 0);
            cdb_grant = ($urandom_range(0, 1) == 1);
            drive(op_list[$urandom_range(0, 7)], 3'($urandom), 1'($urandom), a,
                  ($urandom_range(0, 3) == 0) ? a : $urandom, $urandom, $urandom, 4'($urandom));
            in_config = ($urandom_range(0, 4) < 3);
            @(posedge clk);
            #1;
        end
        in_config = 1'b0; rollback = 1'b0; rdy = 1'b1; cdb_grant = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("final_empty", 32'(out_config), 32'd0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 SHALL have ports: clk in 1 clock; rst in 1 async active-low reset; rdy in 1 global enable; rollback in 1 synchronous flush.
REQ-003 SHALL have issue inputs: in_config 1 valid; in_value_1 32; in_value_2 32; in_value_pc 32; in_opcode 7; in_precise 3 funct3; in_more_precise 1 funct7[5]; in_imm 32; in_rob_entry 4.
REQ-004 SHALL have broadcast outputs: out_config 1 result valid; out_val 32 result; out_rob_entry 4 tag; out_jump 1 redirect taken; out_target_pc 32 next PC.
REQ-005 SHALL have handshake ports: cdb_grant in 1 pops head; almost_full out 1 count>=3.

Function
REQ-006 SHALL compute each issued op combinationally and push {val, rob_entry, jump, target} into a 4-entry result FIFO on the clk edge where rdy=1, in_config=1 and rollback=0.
REQ-007 SHALL drive out_* from the FIFO head; out_config=1 iff count>0; issue at edge N makes result visible from cycle N+1 when FIFO was empty.
REQ-008 SHALL pop the head on an edge with rdy=1, out_config=1, cdb_grant=1; cdb_grant while empty is ignored.
REQ-009 SHALL allow push and pop on the same edge at any count, including 4, leaving count unchanged.
REQ-010 SHALL drop a push when count=4 and no pop; the dispatcher must not issue while almost_full=1.
REQ-011 SHALL wrap 2-bit head/tail pointers modulo 4.
REQ-012 SHALL decode in_opcode: 0110011 OP (v1 op v2); 0010011 OP-IMM (v1 op imm); 0110111 LUI (imm); 0010111 AUIPC (pc+imm); 1101111 JAL; 1100111 JALR; 1100011 BRANCH.
REQ-013 SHALL use funct3: 000 ADD/SUB (SUB only for OP with more_precise=1); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL/SRA (SRA when more_precise=1); 110 OR; 111 AND; shift amount = low 5 bits.
REQ-014 SHALL for JAL: val=pc+4, jump=1, target=pc+imm; JALR: val=pc+4, jump=1, target=(v1+imm)&~1.
REQ-015 SHALL for BRANCH: val=0; funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; jump=cond; target=pc+imm if taken else pc+4.
REQ-016 SHALL for non-control ops set jump=0, target=pc+4; unknown opcode yields val=0, jump=0.
REQ-017 SHALL wrap all arithmetic modulo 2^32.
REQ-018 SHALL on rollback=1 (with rdy=1) empty the FIFO and discard same-cycle issue and grant.
REQ-019 SHALL while rdy=0 hold all state; no push, pop or flush.

Reset
REQ-020 SHALL on rst=0 immediately clear count, head, tail; out_config=0, almost_full=0, out_val=0, out_rob_entry=0, out_jump=0, out_target_pc=0.
REQ-021 SHALL discard in-flight results on mid-operation reset; first legal push after rst release returns to normal operation.

Configuration
REQ-022 SHALL with ALU_BRANCH_STAT_EN defined add outputs stat_branch_cnt 32 and stat_taken_cnt 32, incremented on each push of a BRANCH op (taken count when jump=1), cleared by reset, not by rollback, wrapping at 2^32.
REQ-023 SHALL without ALU_BRANCH_STAT_EN omit those ports and counters entirely; all other behaviour identical.

Verification
REQ-024 SHALL test ADD: v1=5, v2=7, opcode 0110011, funct3 000, rob 3 -> next cycle out_config=1, out_val=12, out_rob_entry=3, out_jump=0.
REQ-025 SHALL test SRA: v1=0x80000000, imm=4, OP-IMM, funct3 101, more_precise=1 -> out_val=0xF8000000.
REQ-026 SHALL test BLT: v1=0xFFFFFFFF, v2=1, pc=0x100, imm=0x20 -> out_jump=1, out_target_pc=0x120; BLTU same operands -> jump=0, target=0x104.
REQ-027 SHALL test fill: 4 issues, cdb_grant=0 -> almost_full=1 after 3rd; 4th-cycle push+grant keeps count=4; heads emerge in issue order.
REQ-028 SHALL test rollback with 2 queued and concurrent issue -> next cycle out_config=0, count=0.
REQ-029 SHALL test JALR: v1=0x1003, imm=2, pc=0x40 -> out_val=0x44, out_target_pc=0x1004, out_jump=1.
